mul_booth_r4: RTL and testbench
===============================

Name: mul_booth_r4

Overview:
- Iterative radix-4 Booth multiplier, parametrised in operand width; successor to the radix-2 execute-stage multiplier.
- Retires two multiplier bits per cycle and supports all four RISC-V M-extension product modes (MUL, MULH, MULHSU, MULHU) via per-operand signedness and a high/low select.
- Uses a valid/ready handshake on both sides plus a kill input for pipeline flush. Sits beside the ALU in the execute stage.

Parameters:
- XLEN, 32, operand width in bits. Must be even and at least 4.
- ITER, (XLEN+2)/2, derived number of radix-4 steps. Not overridable.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- a  in  XLEN  multiplicand (rs1)
- b  in  XLEN  multiplier (rs2)
- a_signed  in  1  treat a as two's complement
- b_signed  in  1  treat b as two's complement
- hi  in  1  1 = return product[2*XLEN-1:XLEN], 0 = return product[XLEN-1:0]
- kill  in  1  abort the in-flight operation
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- result  out  XLEN  selected product half

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on port reset. While reset is high at a clk edge: state=IDLE, out_valid=0, result=0, step counter=0, accumulator=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=out_ready.
- Accept: an edge with in_valid&in_ready captures the operands and hi, and enters RUN with counter=0. Each operand is extended to XLEN+2 bits, sign-extended if its signed flag is set, else zero-extended. The Booth register is initialised to {extended b, 1'b0}.
- RUN step, one per cycle:
  - Decode the digit from the low 3 Booth bits as {0,+1,+1,+2,-2,-1,-1,0}.
  - Add the selected multiple of extended a (0, ±A, ±2A) to the upper partial product using XLEN+4-bit arithmetic.
  - Arithmetic-shift the combined register right by 2.
  - Increment the counter.
- After step ITER-1 the next edge enters DONE, and result latches the selected half of the 2*XLEN-bit product.
- Latency: out_valid first high exactly ITER cycles after the accept edge (17 for XLEN=32).
- DONE:
  - result is held stable until out_valid&out_ready.
  - out_ready=1 with in_valid=0: go to IDLE on the same edge.
  - out_ready=1 with in_valid=1: the new request is accepted on the same edge and the block goes straight to RUN (back-to-back, no bubble).
- kill:
  - Sampled at every edge; it overrides everything except reset.
  - kill=1 in RUN or DONE: go to IDLE, out_valid=0, and discard the result.
  - kill=1 coincident with an accept: the request is dropped and the block stays or goes to IDLE.
- Reset mid-operation: the operation is discarded with no output.
- Input operand ports are don't-care outside the accept edge.
- hi=0 ignores the signedness flags in the result, because the low half is identical for all modes.
- Boundary: the most-negative × most-negative signed case must be exact (this is why operands carry the 2-bit guard).

Optional Feature:
- Macro: MUL_BOOTH_ZERO_BYPASS_EN.
- Defined: if a==0 or b==0 at the accept edge, the block skips RUN and enters DONE on the next edge with result=0. Latency is 1 cycle.
- Not defined: all operations take ITER cycles regardless of operand values.
- Handshake and kill rules are unchanged in both cases.

Decomposition:
- Package mul_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - the Booth digit struct {neg, one, two}
  - a function computing ITER from XLEN
- Sub-module mul_booth_r4_enc: combinational 3-bit → digit struct encoder, instantiated once.

Test Plan:
- MUL: a=7, b=-3 (0xFFFFFFFD), both signed, hi=0 → result 0xFFFFFFEB, out_valid exactly 17 cycles after accept.
- MULHU: a=b=0xFFFFFFFF, unsigned, hi=1 → 0xFFFFFFFE. Same operands with hi=0 → 0x00000001.
- MULH and MULHSU:
  - a=b=0x80000000, both signed, hi=1 → 0x40000000.
  - MULHSU a=0xFFFFFFFF (signed), b=0xFFFFFFFF (unsigned), hi=1 → 0xFFFFFFFF.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → result and out_valid stable and in_ready=0. Then raise out_ready with in_valid=1 → second request accepted on the same edge, and its result arrives 17 cycles later.
- Abort: assert kill at RUN step 8 → IDLE the next cycle and no out_valid. Assert reset mid-RUN → all outputs 0 and in_ready=1 after release.
- With MUL_BOOTH_ZERO_BYPASS_EN: a=0, b=0x12345678 → out_valid one cycle after accept, result=0. Without the macro: the same stimulus takes 17 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, Booth digit
// encoding and the step-count helper.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit value is (neg ? -1 : +1) * (two ? 2 : one ? 1 : 0)
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    function automatic int calc_iter(input int xlen);
        return (xlen + 2) / 2;
    endfunction

endpackage

// File: rtl/mul_booth_r4_enc.sv
// Radix-4 Booth recoder: maps three overlapping multiplier bits to a digit
// in {-2,-1,0,+1,+2}.
module mul_booth_r4_enc
    import mul_pkg::*;
(
    input  logic [2:0]   bits_i,
    output booth_digit_t digit_o
);

    always_comb begin
        digit_o = '0;
        case (bits_i)
            3'b001, 3'b010: digit_o.one = 1'b1;
            3'b011:         digit_o.two = 1'b1;
            3'b100: begin
                digit_o.neg = 1'b1;
                digit_o.two = 1'b1;
            end
            3'b101, 3'b110: begin
                digit_o.neg = 1'b1;
                digit_o.one = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mul_booth_r4.sv
// Iterative radix-4 Booth multiplier covering MUL/MULH/MULHSU/MULHU.
// Optional MUL_BOOTH_ZERO_BYPASS_EN: zero operands finish one cycle after accept.
module mul_booth_r4
    import mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            a_signed,
    input  logic            b_signed,
    input  logic            hi,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int ITER  = calc_iter(XLEN);
    localparam int EW    = XLEN + 2;   // extended operand width
    localparam int AW    = XLEN + 4;   // upper partial product width
    localparam int BW    = XLEN + 3;   // Booth register {b_ext, 0}
    localparam int CNT_W = $clog2(ITER + 1);

    state_t            state_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   result_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [AW-1:0]     acc_q;
    logic [BW-1:0]     booth_q;
    logic [EW-1:0]     a_ext_q;
    logic              hi_q;

    booth_digit_t      digit;
    logic [AW-1:0]     mult_pos;
    logic [AW-1:0]     mult;
    logic [AW-1:0]     sum;
    logic [AW-1:0]     acc_d;
    logic [BW-1:0]     booth_d;
    logic [XLEN-1:0]   result_d;
    logic [EW-1:0]     a_ext_d;
    logic [EW-1:0]     b_ext_d;
    logic              accept;
    logic              zero_op;

    mul_booth_r4_enc u_enc (
        .bits_i  (booth_q[2:0]),
        .digit_o (digit)
    );

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign accept    = in_valid && in_ready;

    assign a_ext_d = a_signed ? {{2{a[XLEN-1]}}, a} : {2'b00, a};
    assign b_ext_d = b_signed ? {{2{b[XLEN-1]}}, b} : {2'b00, b};

`ifdef MUL_BOOTH_ZERO_BYPASS_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        mult_pos = '0;
        if (digit.one) begin
            mult_pos = {{2{a_ext_q[EW-1]}}, a_ext_q};
        end else if (digit.two) begin
            mult_pos = {a_ext_q[EW-1], a_ext_q, 1'b0};
        end
        mult = digit.neg ? (~mult_pos + 1'b1) : mult_pos;
        sum  = acc_q + mult;
        {acc_d, booth_d} = $signed({sum, booth_q}) >>> 2;
        // After the last shift the product sits one bit above the bottom of {acc, booth}
        result_d = hi_q ? {acc_d[XLEN-3:0], booth_d[BW-1:BW-2]} : booth_d[XLEN:1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            booth_q     <= '0;
            a_ext_q     <= '0;
            hi_q        <= 1'b0;
        end else if (kill) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            a_ext_q     <= a_ext_d;
            hi_q        <= hi;
            if (zero_op) begin
                // A single all-zero step lands in DONE with a zero product
                cnt_q   <= CNT_W'(ITER - 1);
                booth_q <= '0;
            end else begin
                cnt_q   <= '0;
                booth_q <= {b_ext_d, 1'b0};
            end
        end else begin
            case (state_q)
                IDLE: ;
                RUN: begin
                    acc_q   <= acc_d;
                    booth_q <= booth_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= result_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_booth_r4.sv
// Directed self-checking bench for mul_booth_r4 (XLEN=32).
module tb_mul_booth_r4;

    localparam int XLEN = 32;
    localparam int LAT  = 17;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            a_signed;
    logic            b_signed;
    logic            hi;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_booth_r4 #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .hi        (hi),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge; block is assumed ready.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                         input logic as, input logic bs, input logic h);
        a = av; b = bv; a_signed = as; b_signed = bs; hi = h;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Cycles from the accept edge until out_valid, or -1 after 40 cycles.
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!out_valid) n = -1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (result !== 32'h0) begin
            failures++;
            $display("FAIL reset_result: got %h expected 00000000", result);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        $display("reset: out_valid=%b result=%h in_ready=%b", out_valid, result, in_ready);
    endtask

    task automatic test_products();
        logic [31:0] va[12];
        logic [31:0] vb[12];
        logic [31:0] ve[12];
        logic        vas[12];
        logic        vbs[12];
        logic        vh[12];
        int          n;
        va  = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                32'hFFFFFFFF, 32'hFFFFFFFB, 32'd100, 32'h80000000, 32'h80000000, 32'h80000000};
        vb  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                32'hFFFFFFFF, 32'h7, 32'd200, 32'h7FFFFFFF, 32'h2, 32'hFFFFFFFF};
        vas = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vbs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vh  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        ve  = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000001, 32'h40000000, 32'h00000000, 32'hFFFFFFFF,
                32'h00000001, 32'hFFFFFFFF, 32'h00004E20, 32'hC0000000, 32'h00000001, 32'h80000000};
        for (int i = 0; i < 12; i++) begin
            issue(va[i], vb[i], vas[i], vbs[i], vh[i]);
            wait_out(n);
            checks++;
            if (n !== LAT) begin
                failures++;
                $display("FAIL product%0d_latency: got %0d cycles expected %0d", i, n, LAT);
            end
            checks++;
            if (result !== ve[i]) begin
                failures++;
                $display("FAIL product%0d_result: got %h expected %h", i, result, ve[i]);
            end
            $display("product%0d: a=%h b=%h as=%b bs=%b hi=%b -> %h lat=%0d",
                     i, va[i], vb[i], vas[i], vbs[i], vh[i], result, n);
            drain();
        end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
        wait_out(n);
        checks++;
        if (n !== LAT) begin
            failures++;
            $display("FAIL bp_first_latency: got %0d expected %0d", n, LAT);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd15 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: got valid=%b result=%h ready=%b expected 1/0000000f/0",
                         i, out_valid, result, in_ready);
            end
        end
        out_ready = 1'b1;
        a = 32'd6; b = 32'd7; a_signed = 1'b0; b_signed = 1'b0; hi = 1'b0;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_in_done: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_second_accepted: got valid=%b ready=%b expected 0/0", out_valid, in_ready);
        end
        wait_out(n);
        checks++;
        if (n !== LAT) begin
            failures++;
            $display("FAIL bp_second_latency: got %0d expected %0d", n, LAT);
        end
        checks++;
        if (result !== 32'd42) begin
            failures++;
            $display("FAIL bp_second_result: got %h expected 0000002a", result);
        end
        $display("back_to_back: second result=%h lat=%0d", result, n);
        drain();
    endtask

    task automatic test_kill();
        int n;
        logic seen;
        // kill at RUN step 8
        issue(32'd11, 32'd13, 1'b0, 1'b0, 1'b0);
        repeat (8) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL kill_run: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
        seen = 1'b0;
        repeat (25) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL kill_run_no_output: got out_valid seen=%b expected 0", seen);
        end
        $display("kill_run: valid=%b ready=%b seen=%b", out_valid, in_ready, seen);
        // kill coincident with accept
        a = 32'd3; b = 32'd3; a_signed = 1'b0; b_signed = 1'b0; hi = 1'b0;
        in_valid = 1'b1;
        kill = 1'b1;
        tick();
        in_valid = 1'b0;
        kill = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            if (out_valid || !in_ready) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL kill_accept: got busy/valid seen=%b expected 0", seen);
        end
        $display("kill_accept: seen=%b", seen);
        // kill while holding a result in DONE
        issue(32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
        wait_out(n);
        checks++;
        if (n !== LAT || result !== 32'd9) begin
            failures++;
            $display("FAIL kill_done_setup: got lat=%0d result=%h expected %0d/00000009", n, result, LAT);
        end
        kill = 1'b1;
        tick();
        kill = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL kill_done: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
        $display("kill_done: valid=%b ready=%b", out_valid, in_ready);
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen;
        issue(32'd1234, 32'd5678, 1'b0, 1'b0, 1'b1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: got valid=%b result=%h ready=%b expected 0/00000000/1",
                     out_valid, result, in_ready);
        end
        seen = 1'b0;
        repeat (25) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_output: got seen=%b expected 0", seen);
        end
        issue(32'd9, 32'd9, 1'b1, 1'b1, 1'b0);
        wait_out(n);
        checks++;
        if (n !== LAT || result !== 32'd81) begin
            failures++;
            $display("FAIL reset_recover: got lat=%0d result=%h expected %0d/00000051", n, result, LAT);
        end
        $display("reset_mid: recover result=%h lat=%0d", result, n);
        drain();
    endtask

    task automatic test_zero_bypass();
        int n;
        int exp_lat;
`ifdef MUL_BOOTH_ZERO_BYPASS_EN
        exp_lat = 1;
`else
        exp_lat = LAT;
`endif
        issue(32'h0, 32'h12345678, 1'b0, 1'b0, 1'b0);
        wait_out(n);
        checks++;
        if (n !== exp_lat) begin
            failures++;
            $display("FAIL zero_a_latency: got %0d expected %0d", n, exp_lat);
        end
        checks++;
        if (result !== 32'h0) begin
            failures++;
            $display("FAIL zero_a_result: got %h expected 00000000", result);
        end
        $display("zero_a: result=%h lat=%0d", result, n);
        drain();
        issue(32'hFFFFFFFB, 32'h0, 1'b1, 1'b1, 1'b1);
        wait_out(n);
        checks++;
        if (n !== exp_lat || result !== 32'h0) begin
            failures++;
            $display("FAIL zero_b: got lat=%0d result=%h expected %0d/00000000", n, result, exp_lat);
        end
        $display("zero_b: result=%h lat=%0d", result, n);
        drain();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        a_signed = 1'b0; b_signed = 1'b0; hi = 1'b0; kill = 1'b0; out_ready = 1'b0;
        test_reset();
        test_products();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        test_zero_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
